// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and helpers for the binary-to-BCD converter and the display stage.
package bin_to_bcd_seq_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

   // Segment pattern that shows a dark digit on the 7-segment display.
   localparam logic [6:0] SEG_BLANK = 7'b000_0000;

   // Number of BCD digits needed to hold any width-bit unsigned value.
   function automatic int unsigned int_digits(input int unsigned width);
      return (width * 32'd1233) / 32'd4096 + 32'd1;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// start/busy/done conversion handshake plus the packed BCD result bus.
interface bin_to_bcd_seq_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DIGITS = 8
);
   logic                  start;
   logic [WIDTH-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic [DIGITS-1:0]     blank;
   logic                  overflow;

   modport master (
      output start, bin_in,
      input  busy, done, bcd_out, blank, overflow
   );

   modport slave (
      input  start, bin_in,
      output busy, done, bcd_out, blank, overflow
   );
endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction: digits of 5 or more get 3 added before the shift.
module bcd_add3
   import bin_to_bcd_seq_pkg::*;
(
   input  bcd_digit_t din,
   output bcd_digit_t dout
);

   // Correct one digit; the result never exceeds 12, so 4 bits suffice.
   always_comb begin
      dout = (din >= 4'd5) ? din + 4'd3 : din;
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-packed-BCD converter with leading-zero blank mask.
module bin_to_bcd_seq
   import bin_to_bcd_seq_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DIGITS = 8
)(
   input  logic              clk,
   input  logic              reset,
   bin_to_bcd_seq_if.slave   bus
);

   localparam int unsigned INT_DIGITS = int_digits(WIDTH);
   localparam int unsigned TOT_DIGITS = (INT_DIGITS > DIGITS) ? INT_DIGITS : DIGITS;
   localparam int unsigned CW         = $clog2(WIDTH + 1);
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

   conv_state_t               state_q, state_d;
   logic [WIDTH-1:0]          shreg_q, shreg_d;
   logic [4*INT_DIGITS-1:0]   bcd_q, bcd_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [4*DIGITS-1:0]       bcd_out_q, bcd_out_d;
   logic [DIGITS-1:0]         blank_q, blank_d;
   logic                      overflow_q, overflow_d;
   logic                      done_q, done_d;

   logic [4*INT_DIGITS-1:0]   bcd_adj;
   logic [4*TOT_DIGITS-1:0]   bcd_ext;
   logic [4*DIGITS-1:0]       res_bcd;
   logic [DIGITS-1:0]         res_blank;
   logic                      res_ovf;
   logic                      zero_run;

   for (genvar g = 0; g < INT_DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .din  (bcd_q[4*g +: 4]),
         .dout (bcd_adj[4*g +: 4])
      );
   end

   // Derive the displayed digits, overflow flag and leading-zero mask from the finished conversion.
   always_comb begin
      bcd_ext  = '0;
      bcd_ext[4*INT_DIGITS-1:0] = bcd_q;
      res_bcd  = bcd_ext[4*DIGITS-1:0];
      res_ovf  = 1'b0;
      for (int unsigned i = DIGITS; i < TOT_DIGITS; i++) begin
         res_ovf = res_ovf | (bcd_ext[4*i +: 4] != 4'd0);
      end
      res_blank = '0;
      zero_run  = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         zero_run = zero_run & (res_bcd[4*(DIGITS-1-i) +: 4] == 4'd0);
         res_blank[DIGITS-1-i] = zero_run & ((DIGITS - 1 - i) != 0);
      end
   end

   // Next-state and datapath control; DONE latches results and may accept a new start.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      bcd_out_d  = bcd_out_q;
      blank_d    = blank_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shreg_d = bus.bin_in;
               bcd_d   = '0;
               cnt_d   = CW'(WIDTH);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
            cnt_d = cnt_q - CW'(1);
            // cnt_q==1 means this edge shifts in the last input bit.
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bcd_out_d  = res_bcd;
            blank_d    = res_blank;
            overflow_d = res_ovf;
            done_d     = 1'b1;
            if (bus.start) begin
               shreg_d = bus.bin_in;
               bcd_d   = '0;
               cnt_d   = CW'(WIDTH);
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         bcd_out_q  <= '0;
         blank_q    <= BLANK_RST;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         bcd_out_q  <= bcd_out_d;
         blank_q    <= blank_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   assign bus.busy     = (state_q == SHIFT);
   assign bus.done     = done_q;
   assign bus.bcd_out  = bcd_out_q;
   assign bus.blank    = blank_q;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized and directed bench for bin_to_bcd_seq against an arithmetic decimal model.
module tb_bin_to_bcd_seq;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned DIGITS = 8;
   localparam int          LAT    = 33;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bif ();

   bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: decimal digits by plain division, overflow and blanking from the digit values.
   task automatic model(input logic [31:0] v, output logic [31:0] b,
                        output logic [7:0] bl, output logic ov);
      longint unsigned x;
      x  = longint'(v);
      ov = (x >= 64'd100000000);
      x  = x % 64'd100000000;
      b  = '0;
      for (int i = 0; i < 8; i++) begin
         b[4*i +: 4] = 4'(x % 64'd10);
         x = x / 64'd10;
      end
      bl = '0;
      for (int k = 1; k < 8; k++) begin
         bl[k] = ((b >> (4*k)) == 32'd0);
      end
   endtask

   // Issue one conversion; returns edges from acceptance to first visible done (-1 on timeout).
   task automatic do_conv(input logic [31:0] v, output int cyc);
      bif.bin_in = v;
      bif.start  = 1'b1;
      @(posedge clk); #1;
      bif.start  = 1'b0;
      bif.bin_in = $urandom;
      cyc = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (bif.done) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bif.start = 1'b0;
      bif.bin_in = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bif.busy !== 1'b0 || bif.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: busy=%b done=%b required busy=0 done=0", bif.busy, bif.done);
      end
      checks++;
      if (bif.bcd_out !== 32'h0 || bif.blank !== 8'hFE || bif.overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: bcd=%h blank=%h ovf=%b required 00000000 fe 0",
                  bif.bcd_out, bif.blank, bif.overflow);
      end
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bif.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_nodone: done=%b required 0", bif.done);
      end
   endtask

   task automatic test_directed();
      logic [31:0] vals [6];
      logic [31:0] eb;
      logic [7:0]  ebl;
      logic        eov;
      int          cyc;
      vals = '{32'd0, 32'd12345678, 32'd99999999, 32'd100000000, 32'hFFFFFFFF, 32'd42};
      foreach (vals[i]) begin
         model(vals[i], eb, ebl, eov);
         do_conv(vals[i], cyc);
         checks++;
         if (cyc != LAT) begin
            errors++;
            $display("FAIL dir_latency[%0d]: got %0d cycles required %0d", i, cyc, LAT);
         end
         checks++;
         if (bif.bcd_out !== eb || bif.blank !== ebl || bif.overflow !== eov) begin
            errors++;
            $display("FAIL dir_result[%0d] in=%0d: bcd=%h blank=%h ovf=%b required %h %h %b",
                     i, vals[i], bif.bcd_out, bif.blank, bif.overflow, eb, ebl, eov);
         end
         @(posedge clk); #1;
         checks++;
         if (bif.done !== 1'b0 || bif.bcd_out !== eb) begin
            errors++;
            $display("FAIL dir_hold[%0d]: done=%b bcd=%h required 0 %h", i, bif.done, bif.bcd_out, eb);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] v;
      logic [31:0] eb;
      logic [7:0]  ebl;
      logic        eov;
      int          cyc;
      for (int n = 0; n < 40; n++) begin
         case (n % 4)
            0: v = $urandom;
            1: v = $urandom_range(99999999, 0);
            2: v = $urandom_range(9999, 0);
            default: v = $urandom_range(999, 0) * 32'd100000;
         endcase
         model(v, eb, ebl, eov);
         do_conv(v, cyc);
         checks++;
         if (cyc != LAT || bif.bcd_out !== eb || bif.blank !== ebl || bif.overflow !== eov) begin
            errors++;
            $display("FAIL rand[%0d] in=%0d: cyc=%0d bcd=%h blank=%h ovf=%b required cyc=%0d %h %h %b",
                     n, v, cyc, bif.bcd_out, bif.blank, bif.overflow, LAT, eb, ebl, eov);
         end
      end
   endtask

   task automatic test_ignore_start();
      logic [31:0] a, prev;
      logic [31:0] eb;
      logic [7:0]  ebl;
      logic        eov;
      int          ndone, first, busy_bad, hold_bad;
      a = $urandom_range(99999999, 10000000);
      model(a, eb, ebl, eov);
      prev = bif.bcd_out;
      ndone = 0; first = -1; busy_bad = 0; hold_bad = 0;
      bif.bin_in = a;
      bif.start  = 1'b1;
      @(posedge clk); #1;
      bif.start  = 1'b0;
      for (int i = 1; i <= 45; i++) begin
         bif.start  = (i == 4 || i == 19);
         bif.bin_in = $urandom;
         @(posedge clk); #1;
         if (i <= 31 && bif.busy !== 1'b1) busy_bad++;
         if (i < LAT && bif.bcd_out !== prev) hold_bad++;
         if (bif.done) begin
            ndone++;
            if (first < 0) first = i;
         end
      end
      bif.start = 1'b0;
      checks++;
      if (ndone != 1 || first != LAT) begin
         errors++;
         $display("FAIL ignore_start_done: dones=%0d first=%0d required 1 at %0d", ndone, first, LAT);
      end
      checks++;
      if (busy_bad != 0 || hold_bad != 0) begin
         errors++;
         $display("FAIL ignore_start_busy: busy_low=%0d out_changed=%0d required 0 0", busy_bad, hold_bad);
      end
      checks++;
      if (bif.bcd_out !== eb || bif.blank !== ebl || bif.overflow !== eov) begin
         errors++;
         $display("FAIL ignore_start_result: bcd=%h blank=%h ovf=%b required %h %h %b",
                  bif.bcd_out, bif.blank, bif.overflow, eb, ebl, eov);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b;
      logic [31:0] ea, eb;
      logic [7:0]  ebla, eblb;
      logic        eova, eovb;
      int          cyc_a, cyc_b;
      a = $urandom;
      b = $urandom_range(999999, 0);
      model(a, ea, ebla, eova);
      model(b, eb, eblb, eovb);
      cyc_a = -1; cyc_b = -1;
      bif.bin_in = a;
      bif.start  = 1'b1;
      @(posedge clk); #1;
      bif.start  = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 32) begin
            bif.start  = 1'b1;
            bif.bin_in = b;
         end
         @(posedge clk); #1;
         if (i == LAT) bif.start = 1'b0;
         if (bif.done && cyc_a < 0) begin
            cyc_a = i;
            break;
         end
      end
      bif.start = 1'b0;
      checks++;
      if (cyc_a != LAT || bif.bcd_out !== ea || bif.blank !== ebla || bif.overflow !== eova) begin
         errors++;
         $display("FAIL b2b_first: cyc=%0d bcd=%h blank=%h ovf=%b required cyc=%0d %h %h %b",
                  cyc_a, bif.bcd_out, bif.blank, bif.overflow, LAT, ea, ebla, eova);
      end
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bif.done) begin
            cyc_b = i;
            break;
         end
      end
      checks++;
      if (cyc_b != LAT || bif.bcd_out !== eb || bif.blank !== eblb || bif.overflow !== eovb) begin
         errors++;
         $display("FAIL b2b_second: cyc=%0d bcd=%h blank=%h ovf=%b required cyc=%0d %h %h %b",
                  cyc_b, bif.bcd_out, bif.blank, bif.overflow, LAT, eb, eblb, eovb);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      logic [31:0] eb;
      logic [7:0]  ebl;
      logic        eov;
      int          cyc, ndone;
      do_conv(32'd87654321, cyc);
      bif.bin_in = 32'd55555;
      bif.start  = 1'b1;
      @(posedge clk); #1;
      bif.start  = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.bcd_out !== 32'h0 ||
          bif.blank !== 8'hFE || bif.overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_out: busy=%b done=%b bcd=%h blank=%h ovf=%b required 0 0 00000000 fe 0",
                  bif.busy, bif.done, bif.bcd_out, bif.blank, bif.overflow);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      ndone = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bif.done) ndone++;
      end
      checks++;
      if (ndone != 0 || bif.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_nodone: dones=%0d busy=%b required 0 0", ndone, bif.busy);
      end
      v = $urandom;
      model(v, eb, ebl, eov);
      do_conv(v, cyc);
      checks++;
      if (cyc != LAT || bif.bcd_out !== eb || bif.blank !== ebl || bif.overflow !== eov) begin
         errors++;
         $display("FAIL reset_mid_fresh in=%0d: cyc=%0d bcd=%h blank=%h ovf=%b required cyc=%0d %h %h %b",
                  v, cyc, bif.bcd_out, bif.blank, bif.overflow, LAT, eb, ebl, eov);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
